// File: rtl/lag_fc_pkg.sv
// rtl/lag_fc_pkg.sv - width helpers and shared types for PL credit flow control
package lag_fc_pkg;

  function automatic int priv_width(input int init_credits);
    return $clog2(init_credits + 1);
  endfunction

  // A disabled pool still needs a 1-bit register so ports keep a legal width.
  function automatic int pool_width(input int shared_credits);
    return (shared_credits == 0) ? 1 : $clog2(shared_credits + 1);
  endfunction

  function automatic int ret_width(input int max_ret);
    return $clog2(max_ret + 1);
  endfunction

  function automatic int ptr_width(input int num_pls);
    return (num_pls > 1) ? $clog2(num_pls) : 1;
  endfunction

  localparam int DEF_RET_BITS = ret_width(2);

  typedef logic [DEF_RET_BITS-1:0] cred_ret_t;

endpackage

// File: rtl/lag_pl_credit_lane.sv
// rtl/lag_pl_credit_lane.sv - per-PL private credit and pool-borrow accounting
module lag_pl_credit_lane
  import lag_fc_pkg::*;
#(
  parameter int init_credits = 4,
  parameter int priv_bits    = priv_width(4),
  parameter int pool_bits    = pool_width(4),
  parameter int ret_bits     = ret_width(2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flit_valid,
  input  logic [ret_bits-1:0]  ret_cnt,
  input  logic                 grant,
  output logic [priv_bits-1:0] priv,
  output logic                 status,
  output logic                 empty,
  output logic [ret_bits-1:0]  repay_cnt,
  output logic                 draw,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int SW = priv_bits + ret_bits;

  logic [priv_bits-1:0] priv_q, priv_d;
  logic [pool_bits-1:0] borrow_q, borrow_d;
  logic [SW-1:0]        ret_w, bor_w, rep_w, sum_w;

  assign priv   = priv_q;
  assign status = (priv_q == '0) && !grant;
  assign empty  = (priv_q == priv_bits'(init_credits)) && (borrow_q == '0);

  always_comb begin
    ret_w     = SW'(ret_cnt);
    bor_w     = SW'(borrow_q);
    rep_w     = (ret_w < bor_w) ? ret_w : bor_w;
    sum_w     = SW'(priv_q) + (ret_w - rep_w);
    borrow_d  = borrow_q - pool_bits'(rep_w);
    repay_cnt = ret_bits'(rep_w);
    draw      = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;

    // Returns repay the pool first; only the remainder refills the private counter.
    if (sum_w > SW'(init_credits)) begin
      priv_d   = priv_bits'(init_credits);
      overflow = 1'b1;
    end else begin
      priv_d = priv_bits'(sum_w);
    end

    if (flit_valid) begin
      if (priv_d != '0) begin
        priv_d = priv_d - priv_bits'(1);
      end else if (!status) begin
        draw     = 1'b1;
        borrow_d = borrow_d + pool_bits'(1);
      end else begin
        underflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      priv_q   <= priv_bits'(init_credits);
      borrow_q <= '0;
    end else begin
      priv_q   <= priv_d;
      borrow_q <= borrow_d;
    end
  end

endmodule

// File: rtl/lag_pl_fc_out_shared.sv
// rtl/lag_pl_fc_out_shared.sv - output-side PL credit flow control with shared pool
module lag_pl_fc_out_shared
  import lag_fc_pkg::*;
#(
  parameter int num_pls        = 4,
  parameter int init_credits   = 4,
  parameter int shared_credits = 4,
  parameter int max_ret        = 2,
  parameter int priv_bits      = priv_width(init_credits),
  parameter int pool_bits      = pool_width(shared_credits),
  parameter int ret_bits       = ret_width(max_ret)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [num_pls-1:0]             flits_valid,
  input  logic [num_pls*ret_bits-1:0]    cred_ret,
  output logic [num_pls-1:0]             pl_status,
  output logic [num_pls-1:0]             pl_empty,
  output logic [num_pls*priv_bits-1:0]   pl_credits,
  output logic [pool_bits-1:0]           pool_credits,
  output logic                           err_overflow,
  output logic                           err_underflow
);

  localparam int PTR_BITS = ptr_width(num_pls);

  logic [pool_bits-1:0] pool_q, pool_d;
  logic [PTR_BITS-1:0]  share_ptr_q, share_ptr_d;
  logic                 ovf_q, udf_q;

  logic [num_pls-1:0]   grant, draw, ovf_ev, udf_ev;
  logic [ret_bits-1:0]  repay [num_pls];

  for (genvar g = 0; g < num_pls; g++) begin : g_lane
    // Only the PL under share_ptr may draw, so at most one draw per cycle.
    assign grant[g] = (pool_q != '0) && (share_ptr_q == PTR_BITS'(g));

    lag_pl_credit_lane #(
      .init_credits (init_credits),
      .priv_bits    (priv_bits),
      .pool_bits    (pool_bits),
      .ret_bits     (ret_bits)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .flit_valid (flits_valid[g]),
      .ret_cnt    (cred_ret[g*ret_bits +: ret_bits]),
      .grant      (grant[g]),
      .priv       (pl_credits[g*priv_bits +: priv_bits]),
      .status     (pl_status[g]),
      .empty      (pl_empty[g]),
      .repay_cnt  (repay[g]),
      .draw       (draw[g]),
      .overflow   (ovf_ev[g]),
      .underflow  (udf_ev[g])
    );
  end

  // Modular add is exact because the true pool value always fits pool_bits.
  always_comb begin
    pool_d = pool_q;
    for (int i = 0; i < num_pls; i++) begin
      pool_d = pool_d + pool_bits'(repay[i]);
    end
    if (|draw) begin
      pool_d = pool_d - pool_bits'(1);
    end
    share_ptr_d = (share_ptr_q == PTR_BITS'(num_pls - 1)) ? '0 : share_ptr_q + PTR_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pool_q      <= pool_bits'(shared_credits);
      share_ptr_q <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      pool_q      <= pool_d;
      share_ptr_q <= share_ptr_d;
      ovf_q       <= ovf_q | (|ovf_ev);
      udf_q       <= udf_q | (|udf_ev);
    end
  end

  assign pool_credits  = pool_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;

endmodule

// File: tb/tb_lag_pl_fc_out_shared.sv
// tb/tb_lag_pl_fc_out_shared.sv - scoreboard bench for lag_pl_fc_out_shared
module tb_lag_pl_fc_out_shared;
  import lag_fc_pkg::*;

  localparam int NP   = 4;
  localparam int INIT = 4;
  localparam int SH   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  flits_valid = '0;
  logic [7:0]  cred_ret = '0;
  logic [3:0]  pl_status, pl_empty;
  logic [11:0] pl_credits;
  logic [2:0]  pool_credits;
  logic        err_overflow, err_underflow;

  always #5 clk = ~clk;

  lag_pl_fc_out_shared dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flits_valid   (flits_valid),
    .cred_ret      (cred_ret),
    .pl_status     (pl_status),
    .pl_empty      (pl_empty),
    .pl_credits    (pl_credits),
    .pool_credits  (pool_credits),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic [3:0]  em;
    logic [11:0] cr;
    logic [2:0]  pool;
    logic        ovf;
    logic        udf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  int   m_priv[NP];
  int   m_bor[NP];
  int   m_pool, m_ptr;
  bit   m_ovf, m_udf;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_blocked(input int i);
    return (m_priv[i] == 0) && !(m_pool > 0 && m_ptr == i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_priv[i] = INIT;
      m_bor[i]  = 0;
    end
    m_pool = SH;
    m_ptr  = 0;
    m_ovf  = 0;
    m_udf  = 0;
  endtask

  task automatic model_step(input logic [3:0] fv, input logic [7:0] ret);
    int add = 0;
    int drw = 0;
    bit blk[NP];
    cred_ret_t r;
    int rep, p;
    for (int i = 0; i < NP; i++) blk[i] = m_blocked(i);
    for (int i = 0; i < NP; i++) begin
      r   = ret[i*2 +: 2];
      rep = (int'(r) < m_bor[i]) ? int'(r) : m_bor[i];
      m_bor[i] -= rep;
      add      += rep;
      p = m_priv[i] + int'(r) - rep;
      if (p > INIT) begin
        p = INIT;
        m_ovf = 1;
      end
      if (fv[i]) begin
        if (p > 0) p--;
        else if (!blk[i]) begin
          drw++;
          m_bor[i]++;
        end else m_udf = 1;
      end
      m_priv[i] = p;
    end
    m_pool = m_pool + add - drw;
    m_ptr  = (m_ptr + 1) % NP;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < NP; i++) begin
      e.st[i]        = m_blocked(i);
      e.em[i]        = (m_priv[i] == INIT) && (m_bor[i] == 0);
      e.cr[i*3 +: 3] = 3'(m_priv[i]);
    end
    e.pool = 3'(m_pool);
    e.ovf  = m_ovf;
    e.udf  = m_udf;
    return e;
  endfunction

  task automatic cycle(input logic rst, input logic [3:0] fv, input logic [7:0] ret);
    exp_t e;
    @(negedge clk);
    rst_n       = rst;
    flits_valid = fv;
    cred_ret    = ret;
    if (!rst) model_reset();
    else model_step(fv, ret);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check($sformatf("c%0d.status", cyc), int'(pl_status), int'(e.st));
    check($sformatf("c%0d.empty", cyc), int'(pl_empty), int'(e.em));
    check($sformatf("c%0d.credits", cyc), int'(pl_credits), int'(e.cr));
    check($sformatf("c%0d.pool", cyc), int'(pool_credits), int'(e.pool));
    check($sformatf("c%0d.ovf", cyc), int'(err_overflow), int'(e.ovf));
    check($sformatf("c%0d.udf", cyc), int'(err_underflow), int'(e.udf));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".status"}, int'(pl_status), 0);
    check({tag, ".empty"}, int'(pl_empty), 15);
    check({tag, ".credits"}, int'(pl_credits), 12'h924);
    check({tag, ".pool"}, int'(pool_credits), SH);
    check({tag, ".ovf"}, int'(err_overflow), 0);
    check({tag, ".udf"}, int'(err_underflow), 0);
  endtask

  initial begin
    logic [3:0] fv;
    logic [7:0] ret;
    int pool_before, outst, sent;

    model_reset();
    cycle(1'b0, 4'b0, 8'b0);
    cycle(1'b0, 4'b0, 8'b0);
    check_reset_values("rst");

    // idle once so share_ptr sits off PL0 when its private credits run out
    cycle(1'b1, 4'b0, 8'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 4'b0001, 8'b0);
      check($sformatf("p0_send%0d", k), int'(pl_credits[2:0]), 3 - k);
    end
    check("p0_status_at0", int'(pl_status[0]), 1);
    check("p0_empty_at0", int'(pl_empty[0]), 0);

    // obedient sender on PL0: sends only when not blocked
    for (int k = 0; k < 20; k++) begin
      fv = m_blocked(0) ? 4'b0 : 4'b0001;
      cycle(1'b1, fv, 8'b0);
    end
    check("pool_drained", int'(pool_credits), 0);
    check("p0_blocked", int'(pl_status[0]), 1);
    check("no_udf_obedient", int'(err_underflow), 0);

    cycle(1'b1, 4'b0, 8'b0000_0010);
    check("repay1_pool", int'(pool_credits), 2);
    check("repay1_priv", int'(pl_credits[2:0]), 0);
    cycle(1'b1, 4'b0, 8'b0000_0010);
    check("repay2_pool", int'(pool_credits), 4);
    check("repay2_priv", int'(pl_credits[2:0]), 0);
    cycle(1'b1, 4'b0, 8'b0000_0010);
    check("refill_priv", int'(pl_credits[2:0]), 2);
    cycle(1'b1, 4'b0, 8'b0000_0010);
    check("refill_full", int'(pl_empty[0]), 1);

    for (int k = 0; k < 4; k++) cycle(1'b1, 4'b0010, 8'b0);
    cycle(1'b1, 4'b0010, 8'b0000_0100);
    check("p1_send_ret", int'(pl_credits[5:3]), 0);
    check("p1_no_ovf", int'(err_overflow), 0);
    check("p1_no_udf", int'(err_underflow), 0);

    cycle(1'b1, 4'b0, 8'b0001_0000);
    check("p2_ovf", int'(err_overflow), 1);
    check("p2_sat", int'(pl_credits[8:6]), 4);
    cycle(1'b1, 4'b0, 8'b0);
    check("p2_ovf_sticky", int'(err_overflow), 1);

    for (int k = 0; k < 4; k++) cycle(1'b1, 4'b1000, 8'b0);
    sent = 0;
    for (int k = 0; k < 8 && sent == 0; k++) begin
      if (m_blocked(3)) begin
        pool_before = m_pool;
        cycle(1'b1, 4'b1000, 8'b0);
        sent = 1;
      end else cycle(1'b1, 4'b0, 8'b0);
    end
    check("p3_blocked_send_found", sent, 1);
    check("p3_udf", int'(err_underflow), 1);
    check("p3_priv", int'(pl_credits[11:9]), 0);
    check("p3_pool", int'(pool_credits), pool_before);

    // legal random traffic, then a reset in the middle of it
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NP; i++) begin
        fv[i] = !m_blocked(i) && ($urandom_range(0, 1) == 1);
        outst = INIT - m_priv[i] + m_bor[i];
        ret[i*2 +: 2] = 2'($urandom_range(0, (outst < 2) ? outst : 2));
      end
      cycle(1'b1, fv, ret);
    end
    cycle(1'b0, 4'b1111, 8'b1010_1010);
    check_reset_values("midrst");
    cycle(1'b1, 4'b0, 8'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
